plate_char_collector: RTL and testbench
=======================================

PLATE_CHAR_COLLECTOR -- requirements
Module: plate_char_collector

Interface
REQ-001 Parameter STABLE_FRAMES, default 3, number of consecutive identical complete frames required before outputs update; legal range 1..7.
REQ-002 pixelclk  input  1  sole clock; all logic on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 i_vsync  input  1  frame sync from video pipeline, asynchronous to decode logic.
REQ-005 char_valid  input  1  one-cycle strobe: recognizer has a character result.
REQ-006 char_idx  input  3  plate position 0..7; 0 = province character.
REQ-007 char_code  input  16  result code; idx 0 uses [15:0], idx 1..7 use [7:0].
REQ-008 char_result1  output  16  committed province code.
REQ-009 char_result2..char_result8  output  8 each  committed characters for idx 1..7.
REQ-010 vpframe_cnt  output  2  frame counter, modulo 4.
REQ-011 result_valid  output  1  one-cycle pulse when outputs are updated.

Function
REQ-012 i_vsync SHALL pass through a 3-flop chain; vsync_pos = stage2 high AND stage3 low, asserted one cycle per rising edge.
REQ-013 On char_valid, code SHALL be written to shadow[char_idx] and mask[char_idx] set; repeated index within a frame: last write wins.
REQ-014 On vsync_pos (state COLLECT), shadow and mask SHALL be copied to snapshot, mask cleared, state to COMPARE, and vpframe_cnt incremented (3 wraps to 0).
REQ-015 char_valid coincident with vsync_pos SHALL belong to the new frame: written to shadow with its mask bit set after the clear.
REQ-016 COMPARE (1 cycle): if snapshot mask != 8'hFF, match_cnt SHALL clear to 0 and candidate remain unchanged.
REQ-017 COMPARE: complete snapshot equal to candidate (all 8 codes, idx 1..7 compared on [7:0] only) SHALL increment match_cnt, saturating at STABLE_FRAMES.
REQ-018 COMPARE: complete snapshot differing from candidate SHALL load candidate from snapshot and set match_cnt to 1.
REQ-019 State SHALL go COMPARE->COMMIT when updated match_cnt equals STABLE_FRAMES and committed flag is clear, else COMPARE->COLLECT.
REQ-020 COMMIT (1 cycle): outputs SHALL load from candidate, result_valid pulse, committed flag set, return to COLLECT.
REQ-021 Committed flag SHALL clear whenever candidate is reloaded (REQ-018) or match_cnt cleared (REQ-016); an unchanged stable plate commits once only.
REQ-022 Latency: result_valid SHALL assert exactly 2 cycles after the vsync_pos that closes the qualifying frame.
REQ-023 char_valid during COMPARE/COMMIT SHALL still be captured into shadow/mask.
REQ-024 vsync_pos arriving during COMPARE or COMMIT SHALL not occur in legal use (frames >> 2 cycles); if it does, it is ignored, mask is not cleared, vpframe_cnt still increments.
REQ-025 char_result outputs SHALL hold steady between commits (stable for downstream UART sender across frames).

Reset
REQ-026 reset_n low at a clock edge SHALL set: outputs char_result* = 0, result_valid = 0, vpframe_cnt = 0, state = COLLECT, mask = 0, match_cnt = 0, committed = 0, candidate = 0, sync flops = 0.
REQ-027 Reset mid-frame or mid-COMPARE SHALL discard partial results; first frame after release is treated as incomplete unless all 8 indices arrive after release.

Structure
REQ-028 Shared package plate_pkg SHALL hold NUM_CHARS = 8, PROV_W = 16, CHAR_W = 8, state enum {COLLECT, COMPARE, COMMIT}.
REQ-029 Sub-module vsync_edge_det SHALL implement REQ-012; all else in plate_char_collector.

Verification
REQ-030 Three frames each with idx0..7 = 16'hD5E3,"A","B","1","2","3","4","5" -> one result_valid 2 cycles after 3rd vsync_pos; char_result1=16'hD5E3, char_result8="5"; vpframe_cnt=3.
REQ-031 Same plate for 6 frames -> exactly one result_valid; 7th frame differs in idx4 then 3 frames of new plate -> second pulse, char_result5 updated.
REQ-032 Frame 2 of 3 omits idx7 -> no pulse after frame 3; pulse after frame 5 (frames 3,4,5 complete and equal).
REQ-033 char_valid idx0 on same cycle as vsync_pos -> value appears in next frame's snapshot, not the closing one.
REQ-034 reset_n low for 1 cycle between frames 2 and 3 of identical plate -> all outputs 0, no pulse until 3 full frames after release.
REQ-035 STABLE_FRAMES=1: single complete frame -> pulse 2 cycles after its closing vsync_pos; vpframe_cnt wraps 3->0 on 4th edge.

Source files
------------

// File: rtl/plate_char_collector_pkg.sv
// Shared widths, FSM state encoding and plate record for the plate character collector.
package plate_pkg;

    localparam int NUM_CHARS = 8;
    localparam int PROV_W    = 16;
    localparam int CHAR_W    = 8;
    localparam int IDX_W     = 3;
    localparam int MATCH_W   = 3;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPARE = 2'd1,
        COMMIT  = 2'd2
    } state_e;

    // One full plate: 16-bit province code plus seven 8-bit characters (idx 1..7).
    typedef struct packed {
        logic [PROV_W-1:0]                 prov;
        logic [NUM_CHARS-1:1][CHAR_W-1:0]  chars;
    } plate_t;

endpackage

// File: rtl/plate_char_collector_vsync_edge_det.sv
// Three-flop synchronizer for the video vsync with a single-cycle rising-edge pulse.
module vsync_edge_det (
    input  logic pixelclk,
    input  logic reset_n,
    input  logic vsync_i,
    output logic vsync_pos_o
);

    logic [2:0] sync_q;

    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], vsync_i};
        end
    end

    assign vsync_pos_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/plate_char_collector.sv
// Collects per-frame character results and commits a plate once it is seen unchanged
// for STABLE_FRAMES consecutive complete frames (legal range 1..7).
//
// state   | meaning
// COLLECT | capturing characters into shadow, waiting for vsync rising edge
// COMPARE | one cycle: judge the closed frame snapshot against the candidate
// COMMIT  | one cycle: outputs hold the new plate, result_valid is high
module plate_char_collector
    import plate_pkg::*;
#(
    parameter int STABLE_FRAMES = 3
) (
    input  logic        pixelclk,
    input  logic        reset_n,
    input  logic        i_vsync,
    input  logic        char_valid,
    input  logic [2:0]  char_idx,
    input  logic [15:0] char_code,
    output logic [15:0] char_result1,
    output logic [7:0]  char_result2,
    output logic [7:0]  char_result3,
    output logic [7:0]  char_result4,
    output logic [7:0]  char_result5,
    output logic [7:0]  char_result6,
    output logic [7:0]  char_result7,
    output logic [7:0]  char_result8,
    output logic [1:0]  vpframe_cnt,
    output logic        result_valid
);

    localparam logic [MATCH_W-1:0] STABLE_CNT = MATCH_W'(STABLE_FRAMES);

    logic                 vsync_pos;
    state_e               state_q, state_d;
    plate_t               shadow_q, shadow_d;
    plate_t               snap_q, snap_d;
    plate_t               cand_q, cand_d;
    plate_t               result_q, result_d;
    logic [NUM_CHARS-1:0] mask_q, mask_d;
    logic [NUM_CHARS-1:0] snap_mask_q, snap_mask_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic                 committed_q, committed_d;
    logic                 rv_q, rv_d;
    logic [1:0]           vpcnt_q, vpcnt_d;

    vsync_edge_det u_vsync_edge_det (
        .pixelclk    (pixelclk),
        .reset_n     (reset_n),
        .vsync_i     (i_vsync),
        .vsync_pos_o (vsync_pos)
    );

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        snap_d      = snap_q;
        cand_d      = cand_q;
        result_d    = result_q;
        mask_d      = mask_q;
        snap_mask_d = snap_mask_q;
        match_d     = match_q;
        committed_d = committed_q;
        rv_d        = 1'b0;
        vpcnt_d     = vpcnt_q;

        if (vsync_pos) begin
            vpcnt_d = vpcnt_q + 2'd1;
        end

        case (state_q)
            COLLECT: begin
                if (vsync_pos) begin
                    snap_d      = shadow_q;
                    snap_mask_d = mask_q;
                    mask_d      = '0;
                    state_d     = COMPARE;
                end
            end
            COMPARE: begin
                if (snap_mask_q != '1) begin
                    match_d     = '0;
                    committed_d = 1'b0;
                end else if (snap_q == cand_q) begin
                    if (match_q != STABLE_CNT) begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end else begin
                    cand_d      = snap_q;
                    match_d     = MATCH_W'(1);
                    committed_d = 1'b0;
                end
                // Outputs and the pulse are registered on entry so both are valid during COMMIT.
                if ((match_d == STABLE_CNT) && !committed_d) begin
                    result_d = cand_d;
                    rv_d     = 1'b1;
                    state_d  = COMMIT;
                end else begin
                    state_d  = COLLECT;
                end
            end
            COMMIT: begin
                committed_d = 1'b1;
                state_d     = COLLECT;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        // Applied after the frame-boundary clear so a coincident strobe lands in the new frame.
        if (char_valid) begin
            mask_d[char_idx] = 1'b1;
            if (char_idx == '0) begin
                shadow_d.prov = char_code;
            end
            for (int i = 1; i < NUM_CHARS; i++) begin
                if (char_idx == IDX_W'(i)) begin
                    shadow_d.chars[i] = char_code[CHAR_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            state_q     <= COLLECT;
            shadow_q    <= '0;
            snap_q      <= '0;
            cand_q      <= '0;
            result_q    <= '0;
            mask_q      <= '0;
            snap_mask_q <= '0;
            match_q     <= '0;
            committed_q <= 1'b0;
            rv_q        <= 1'b0;
            vpcnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            snap_q      <= snap_d;
            cand_q      <= cand_d;
            result_q    <= result_d;
            mask_q      <= mask_d;
            snap_mask_q <= snap_mask_d;
            match_q     <= match_d;
            committed_q <= committed_d;
            rv_q        <= rv_d;
            vpcnt_q     <= vpcnt_d;
        end
    end

    assign char_result1 = result_q.prov;
    assign char_result2 = result_q.chars[1];
    assign char_result3 = result_q.chars[2];
    assign char_result4 = result_q.chars[3];
    assign char_result5 = result_q.chars[4];
    assign char_result6 = result_q.chars[5];
    assign char_result7 = result_q.chars[6];
    assign char_result8 = result_q.chars[7];
    assign vpframe_cnt  = vpcnt_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_plate_char_collector.sv
// Directed bench: two collectors (STABLE_FRAMES 3 and 1) share one stimulus stream.
module tb_plate_char_collector;

    logic        pixelclk = 1'b0;
    logic        reset_n;
    logic        i_vsync;
    logic        char_valid;
    logic [2:0]  char_idx;
    logic [15:0] char_code;

    logic [15:0] r1_a, r1_b;
    logic [7:0]  ra [2:8];
    logic [7:0]  rb [2:8];
    logic [1:0]  vp_a, vp_b;
    logic        rv_a, rv_b;

    int checks   = 0;
    int failures = 0;
    int exp_vp   = 0;

    always #5 pixelclk = ~pixelclk;

    plate_char_collector #(.STABLE_FRAMES(3)) dut_a (
        .pixelclk(pixelclk), .reset_n(reset_n), .i_vsync(i_vsync),
        .char_valid(char_valid), .char_idx(char_idx), .char_code(char_code),
        .char_result1(r1_a), .char_result2(ra[2]), .char_result3(ra[3]),
        .char_result4(ra[4]), .char_result5(ra[5]), .char_result6(ra[6]),
        .char_result7(ra[7]), .char_result8(ra[8]),
        .vpframe_cnt(vp_a), .result_valid(rv_a)
    );

    plate_char_collector #(.STABLE_FRAMES(1)) dut_b (
        .pixelclk(pixelclk), .reset_n(reset_n), .i_vsync(i_vsync),
        .char_valid(char_valid), .char_idx(char_idx), .char_code(char_code),
        .char_result1(r1_b), .char_result2(rb[2]), .char_result3(rb[3]),
        .char_result4(rb[4]), .char_result5(rb[5]), .char_result6(rb[6]),
        .char_result7(rb[7]), .char_result8(rb[8]),
        .vpframe_cnt(vp_b), .result_valid(rv_b)
    );

    // plate 0 = all zero, 1 = D5E3 "AB12345", 2 = plate 1 with idx4 = "9", 3 = plate 1 with province 1234
    function automatic logic [15:0] plate_code(input int p, input int idx);
        logic [15:0] c;
        case (idx)
            0: c = 16'hD5E3;
            1: c = 16'h0041;
            2: c = 16'h0042;
            3: c = 16'h0031;
            4: c = 16'h0032;
            5: c = 16'h0033;
            6: c = 16'h0034;
            default: c = 16'h0035;
        endcase
        if (p == 2 && idx == 4) c = 16'h0039;
        if (p == 3 && idx == 0) c = 16'h1234;
        if (p == 0) c = 16'h0000;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int pa, input int pb);
        chk($sformatf("%s_a_r1", tag), {16'h0, r1_a}, {16'h0, plate_code(pa, 0)});
        chk($sformatf("%s_b_r1", tag), {16'h0, r1_b}, {16'h0, plate_code(pb, 0)});
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("%s_a_r%0d", tag, i + 1), {24'h0, ra[i + 1]}, {16'h0, plate_code(pa, i)});
            chk($sformatf("%s_b_r%0d", tag, i + 1), {24'h0, rb[i + 1]}, {16'h0, plate_code(pb, i)});
        end
    endtask

    task automatic check_vp(input string tag);
        chk($sformatf("%s_vp_a", tag), {30'h0, vp_a}, exp_vp);
        chk($sformatf("%s_vp_b", tag), {30'h0, vp_b}, exp_vp);
    endtask

    // Upper byte of idx 1..7 codes is random: only [7:0] may matter.
    task automatic send_frame(input int p, input logic [7:0] mask);
        logic [15:0] c;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                @(negedge pixelclk);
                c = plate_code(p, i);
                if (i != 0) c[15:8] = 8'($urandom_range(0, 255));
                char_valid = 1'b1;
                char_idx   = 3'(i);
                char_code  = c;
            end
        end
        @(negedge pixelclk);
        char_valid = 1'b0;
        repeat (2) @(negedge pixelclk);
    endtask

    // Raise vsync; result_valid must be high only at the 4th negedge (2 cycles after the edge pulse).
    task automatic do_vsync(input string tag, input logic inj, input logic [15:0] inj_code,
                            input logic e_a, input logic e_b);
        logic [5:0] o_a, o_b;
        o_a = '0;
        o_b = '0;
        @(negedge pixelclk);
        i_vsync = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge pixelclk);
            o_a[k-1] = rv_a;
            o_b[k-1] = rv_b;
            if (inj && k == 2) begin
                char_valid = 1'b1;
                char_idx   = 3'd0;
                char_code  = inj_code;
            end
            if (k == 3) char_valid = 1'b0;
        end
        i_vsync = 1'b0;
        repeat (3) @(negedge pixelclk);
        exp_vp = (exp_vp + 1) % 4;
        chk($sformatf("%s_pulse_a", tag), {26'h0, o_a}, e_a ? 32'h08 : 32'h0);
        chk($sformatf("%s_pulse_b", tag), {26'h0, o_b}, e_b ? 32'h08 : 32'h0);
        check_vp(tag);
    endtask

    task automatic reset_dut(input int ncyc);
        @(negedge pixelclk);
        reset_n = 1'b0;
        repeat (ncyc) @(negedge pixelclk);
        reset_n = 1'b1;
        exp_vp = 0;
    endtask

    typedef struct {
        int         plate;
        logic [7:0] mask;
        logic       inj;
        logic       e_a;
        logic       e_b;
        int         o_a;
        int         o_b;
    } vec_t;

    vec_t vt [16];

    initial begin
        vt[0]  = '{1, 8'hFF, 1'b0, 1'b0, 1'b1, 0, 1};
        vt[1]  = '{1, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 1};
        vt[2]  = '{1, 8'hFF, 1'b0, 1'b1, 1'b0, 1, 1};
        vt[3]  = '{1, 8'hFF, 1'b0, 1'b0, 1'b0, 1, 1};
        vt[4]  = '{1, 8'hFF, 1'b0, 1'b0, 1'b0, 1, 1};
        vt[5]  = '{1, 8'hFF, 1'b0, 1'b0, 1'b0, 1, 1};
        vt[6]  = '{2, 8'hFF, 1'b0, 1'b0, 1'b1, 1, 2};
        vt[7]  = '{2, 8'hFF, 1'b0, 1'b0, 1'b0, 1, 2};
        vt[8]  = '{2, 8'hFF, 1'b0, 1'b1, 1'b0, 2, 2};
        vt[9]  = '{1, 8'hFF, 1'b0, 1'b0, 1'b1, 2, 1};
        vt[10] = '{1, 8'h7F, 1'b0, 1'b0, 1'b0, 2, 1};
        vt[11] = '{1, 8'hFF, 1'b0, 1'b0, 1'b1, 2, 1};
        vt[12] = '{1, 8'hFF, 1'b0, 1'b0, 1'b0, 2, 1};
        vt[13] = '{1, 8'hFF, 1'b0, 1'b1, 1'b0, 1, 1};
        // Closing vsync carries a coincident idx0 write; the following frame omits idx0.
        vt[14] = '{1, 8'hFF, 1'b1, 1'b0, 1'b0, 1, 1};
        vt[15] = '{3, 8'hFE, 1'b0, 1'b0, 1'b1, 1, 3};

        reset_n    = 1'b0;
        i_vsync    = 1'b0;
        char_valid = 1'b0;
        char_idx   = '0;
        char_code  = '0;
        repeat (4) @(negedge pixelclk);
        reset_n = 1'b1;
        exp_vp  = 0;
        @(negedge pixelclk);
        chk("rst_rv_a", {31'h0, rv_a}, 0);
        chk("rst_rv_b", {31'h0, rv_b}, 0);
        check_vp("rst");
        check_outs("rst", 0, 0);

        // Reset between frames 2 and 3, then a frame split by a mid-frame reset.
        send_frame(1, 8'hFF);
        do_vsync("rs1", 1'b0, 16'h0, 1'b0, 1'b1);
        send_frame(1, 8'hFF);
        do_vsync("rs2", 1'b0, 16'h0, 1'b0, 1'b0);
        check_outs("rs2", 0, 1);
        reset_dut(1);
        @(negedge pixelclk);
        check_outs("rs_clr", 0, 0);
        check_vp("rs_clr");
        send_frame(1, 8'h0F);
        reset_dut(1);
        send_frame(1, 8'hF0);
        do_vsync("rs_part", 1'b0, 16'h0, 1'b0, 1'b0);
        check_outs("rs_part", 0, 0);
        send_frame(1, 8'hFF);
        do_vsync("rs3", 1'b0, 16'h0, 1'b0, 1'b1);
        send_frame(1, 8'hFF);
        do_vsync("rs4", 1'b0, 16'h0, 1'b0, 1'b0);
        send_frame(1, 8'hFF);
        do_vsync("rs5", 1'b0, 16'h0, 1'b1, 1'b0);
        check_outs("rs5", 1, 1);

        reset_dut(2);
        for (int v = 0; v < 16; v++) begin
            send_frame(vt[v].plate, vt[v].mask);
            do_vsync($sformatf("v%0d", v), vt[v].inj, 16'h1234, vt[v].e_a, vt[v].e_b);
            check_outs($sformatf("v%0d", v), vt[v].o_a, vt[v].o_b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
